epsilon_greedy_policy: RTL and testbench
========================================

EPSILON_GREEDY_POLICY -- requirements
Module: epsilon_greedy_policy

Interface
REQ-001 SHALL have parameter NUM_ACTIONS, default 4, number of actions (2..16).
REQ-002 SHALL have parameter Q_WIDTH, default 16, width of each signed Q value (Q8.8 at default).
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-007 SHALL have port q_values, input, NUM_ACTIONS*Q_WIDTH; action i at bits [i*Q_WIDTH +: Q_WIDTH].
REQ-008 SHALL have ports eps_load (input, 1) and eps_init (input, 16): unsigned Q8.8 epsilon load.
REQ-009 SHALL have ports eps_step (input, 16) and eps_min (input, 16): decay per decision and floor, Q8.8.
REQ-010 SHALL have ports out_valid (input-side output, 1) and out_ready (input, 1): result handshake.
REQ-011 SHALL have outputs action (NUM_ACTIONS, one-hot), action_idx ($clog2(NUM_ACTIONS)), explore (1), epsilon_q (16, current epsilon).

Function
REQ-012 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE.
REQ-013 in_ready SHALL be 1 only in IDLE; request accepted when in_valid and in_ready both 1.
REQ-014 On accept: q_values latched, LFSR advances exactly once, FSM -> SCAN; LFSR SHALL not advance otherwise.
REQ-015 SCAN SHALL compare one signed Q per cycle, indices 0..NUM_ACTIONS-1, taking NUM_ACTIONS cycles; ties keep the lowest index.
REQ-016 out_valid SHALL assert NUM_ACTIONS+1 cycles after the accept edge (DONE state).
REQ-017 Explore decision: r = LFSR[7:0]; explore=1 iff {8'h00,r} < epsilon_q; epsilon_q >= 16'h0100 always explores, 0 never.
REQ-018 Explore index SHALL be (LFSR[15:8] * NUM_ACTIONS) >> 8; otherwise greedy argmax index.
REQ-019 action SHALL equal one-hot of action_idx; outputs SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 DONE -> IDLE on out_ready=1; at that handshake epsilon_q <= max(epsilon_q - eps_step, eps_min), no underflow.
REQ-021 If epsilon_q < eps_min before decay, epsilon_q SHALL remain unchanged.
REQ-022 eps_load SHALL set epsilon_q <= eps_init in any state and take priority over decay on the same cycle.
REQ-023 Outputs outside DONE SHALL hold last result (zero after reset); out_valid=0.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, out_valid=0, action=0, action_idx=0, explore=0, epsilon_q=0, LFSR=LFSR_SEED.
REQ-025 Reset mid-SCAN or mid-DONE SHALL abort the decision with no output handshake and no decay.
REQ-026 in_ready SHALL be 0 while rst_n=0 and 1 the first cycle after release.

Structure
REQ-027 Package policy_pkg SHALL hold the FSM state enum, FRAC_BITS=8, EPS_ONE=16'h0100 and LFSR polynomial 16'hB400.
REQ-028 Sub-module lfsr16 SHALL implement the 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with advance enable and seed.
REQ-029 The argmax SHALL be one comparator with index counter and running max register, not a combinational tree.

Verification
REQ-030 epsilon 0, Q{0..3}={0x0003,0x0002,0x0001,0x000C} -> action_idx=3, action=4'b1000, explore=0, out_valid at accept+5.
REQ-031 epsilon 0, Q={0xFF00,0xFE00,0xFF00,0x8000} (signed negatives) -> action_idx=0 (tie to lowest, -1.0 max).
REQ-032 eps_init=0x0100, 20 requests -> explore=1 every time; action_idx = (LFSR[15:8]*4)>>8 matching reference LFSR model.
REQ-033 eps_init=0x00E0, eps_step=0x0040, eps_min=0x0020: epsilon_q 0xE0 -> 0xA0 -> 0x60 -> 0x20 -> 0x20.
REQ-034 out_ready=0 for 10 cycles in DONE -> outputs constant, in_ready=0, no decay until handshake.
REQ-035 rst_n pulsed low during SCAN -> out_valid never asserts; next request with seed LFSR gives same result as after cold reset.

Source files
------------

// File: rtl/policy_pkg.sv
// Shared types and constants for the epsilon-greedy action selector.
// Holds the FSM encoding, Q8.8 constants and the LFSR feedback taps.
package policy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  localparam int          FRAC_BITS = 8;
  localparam logic [15:0] EPS_ONE   = 16'h0100;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

endpackage

// File: rtl/epsilon_greedy_policy_lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting.
// Advances only when enabled; reset loads the seed.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] state
);
  import policy_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (advance) begin
      state <= (state >> 1) ^ (state[0] ? LFSR_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/epsilon_greedy_policy.sv
// Epsilon-greedy action selector: serial argmax over latched Q values,
// LFSR-driven exploration and decaying Q8.8 epsilon.
module epsilon_greedy_policy #(
  parameter int          NUM_ACTIONS = 4,
  parameter int          Q_WIDTH     = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_ACTIONS*Q_WIDTH-1:0] q_values,
  input  logic                           eps_load,
  input  logic [15:0]                    eps_init,
  input  logic [15:0]                    eps_step,
  input  logic [15:0]                    eps_min,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_ACTIONS-1:0]         action,
  output logic [$clog2(NUM_ACTIONS)-1:0] action_idx,
  output logic                           explore,
  output logic [15:0]                    epsilon_q
);
  import policy_pkg::*;

  localparam int IW = $clog2(NUM_ACTIONS);
  localparam int CW = $clog2(NUM_ACTIONS + 1);

  state_t                         state;
  logic [CW-1:0]                  cnt;
  logic [NUM_ACTIONS*Q_WIDTH-1:0] q_lat;
  logic signed [Q_WIDTH-1:0]      best;
  logic [IW-1:0]                  best_idx;
  logic [15:0]                    lfsr;
  logic                           accept;
  logic                           last;
  logic [IW-1:0]                  sel;
  logic signed [Q_WIDTH-1:0]      cur;
  logic [15:0]                    rand_prod;
  logic [IW-1:0]                  rand_idx;
  logic                           explore_n;
  logic [IW-1:0]                  idx_n;
  logic [16:0]                    diff;
  logic [15:0]                    eps_next;

  assign in_ready = rst_n & (state == ST_IDLE);
  assign accept   = in_valid & in_ready;

  lfsr16 #(
    .SEED    (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (accept),
    .state   (lfsr)
  );

  // cnt == NUM_ACTIONS is the extra cycle that publishes the result
  assign last = (cnt == CW'(NUM_ACTIONS));
  assign sel  = last ? '0 : cnt[IW-1:0];
  assign cur  = q_lat[sel*Q_WIDTH +: Q_WIDTH];

  assign rand_prod = {8'h00, lfsr[15:8]} * 16'(NUM_ACTIONS);
  assign rand_idx  = IW'(rand_prod >> FRAC_BITS);
  assign explore_n = (epsilon_q >= EPS_ONE)
                   | ({8'h00, lfsr[7:0]} < epsilon_q);
  assign idx_n     = explore_n ? rand_idx : best_idx;

  always_comb begin
    diff     = {1'b0, epsilon_q} - {1'b0, eps_step};
    eps_next = epsilon_q;
    if (epsilon_q >= eps_min) begin
      if (diff[16] || (diff[15:0] < eps_min)) begin
        eps_next = eps_min;
      end else begin
        eps_next = diff[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      q_lat      <= '0;
      best       <= '0;
      best_idx   <= '0;
      out_valid  <= 1'b0;
      action     <= '0;
      action_idx <= '0;
      explore    <= 1'b0;
      epsilon_q  <= '0;
    end else begin
      if (eps_load) begin
        epsilon_q <= eps_init;
      end
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            q_lat <= q_values;
            cnt   <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (last) begin
            state      <= ST_DONE;
            out_valid  <= 1'b1;
            explore    <= explore_n;
            action_idx <= idx_n;
            action     <= NUM_ACTIONS'(1) << idx_n;
          end else begin
            // strict compare keeps the lowest index on ties
            if ((cnt == '0) || (cur > best)) begin
              best     <= cur;
              best_idx <= sel;
            end
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            if (!eps_load) begin
              epsilon_q <= eps_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epsilon_greedy_policy.sv
// Randomised self-checking bench for epsilon_greedy_policy with a
// cycle-level reference model of the selection and epsilon decay.
module tb_epsilon_greedy_policy;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N*16-1:0] q_values;
  logic          eps_load;
  logic [15:0]   eps_init;
  logic [15:0]   eps_step;
  logic [15:0]   eps_min;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  action;
  logic [1:0]    action_idx;
  logic          explore;
  logic [15:0]   epsilon_q;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_eps;
  logic        m_ready;
  logic        m_valid;
  logic [1:0]  m_idx;
  logic        m_explore;
  logic [3:0]  m_action;
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  epsilon_greedy_policy dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .q_values   (q_values),
    .eps_load   (eps_load),
    .eps_init   (eps_init),
    .eps_step   (eps_step),
    .eps_min    (eps_min),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .action     (action),
    .action_idx (action_idx),
    .explore    (explore),
    .epsilon_q  (epsilon_q)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic lsb;
    lsb = s[0];
    s = s >> 1;
    if (lsb) s = s ^ 16'hB400;
    return s;
  endfunction

  function automatic logic [1:0] argmax(input logic [N*16-1:0] q);
    int b;
    logic signed [15:0] a, m;
    b = 0;
    for (int i = 1; i < N; i++) begin
      a = q[i*16 +: 16];
      m = q[b*16 +: 16];
      if (a > m) b = i;
    end
    return 2'(b);
  endfunction

  function automatic logic [15:0] decay(input logic [15:0] e,
                                        input logic [15:0] s,
                                        input logic [15:0] mn);
    int d;
    if (e < mn) return e;
    d = int'(e) - int'(s);
    return (d < int'(mn)) ? mn : 16'(d);
  endfunction

  task automatic model_reset();
    m_lfsr    = 16'hACE1;
    m_eps     = 16'h0000;
    m_ready   = 1'b1;
    m_valid   = 1'b0;
    m_idx     = 2'd0;
    m_explore = 1'b0;
    m_action  = 4'd0;
  endtask

  // every cycle: DUT must track the model exactly
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("mon_in_ready", in_ready, m_ready);
      chk("mon_out_valid", out_valid, m_valid);
      chk("mon_epsilon", epsilon_q, m_eps);
      chk("mon_action_idx", action_idx, m_idx);
      chk("mon_explore", explore, m_explore);
      chk("mon_action", action, m_action);
    end
  end

  task automatic load_eps(input logic [15:0] v);
    @(negedge clk);
    eps_load = 1'b1;
    eps_init = v;
    @(posedge clk);
    #1;
    m_eps    = v;
    eps_load = 1'b0;
  endtask

  task automatic request(input logic [N*16-1:0] q, input int stall,
                         input bit noisy,
                         output logic [1:0] idx, output logic ex);
    logic [7:0] r;
    @(negedge clk);
    q_values  = q;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    m_lfsr  = lfsr_step(m_lfsr);
    m_ready = 1'b0;
    r  = m_lfsr[7:0];
    ex = (m_eps >= 16'h0100) || ({8'h00, r} < m_eps);
    if (ex) idx = 2'((int'(m_lfsr[15:8]) * N) / 256);
    else    idx = argmax(q);
    if (noisy) q_values = {$urandom, $urandom};
    else       in_valid = 1'b0;
    repeat (N) @(posedge clk);
    @(posedge clk);
    #1;
    chk("latency_valid", out_valid, 1'b1);
    m_valid   = 1'b1;
    m_idx     = idx;
    m_explore = ex;
    m_action  = 4'(1) << idx;
    repeat (stall) @(posedge clk);
    #1;
    chk("stall_in_ready", in_ready, 1'b0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    m_valid   = 1'b0;
    m_ready   = 1'b1;
    m_eps     = decay(m_eps, eps_step, eps_min);
  endtask

  initial begin
    logic [1:0] idx;
    logic       ex;
    logic [15:0] exp_eps [4];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    q_values  = '0;
    eps_load  = 1'b0;
    eps_init  = '0;
    eps_step  = '0;
    eps_min   = '0;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_action", action, 4'd0);
    chk("rst_epsilon", epsilon_q, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1'b1);
    mon_en = 1'b1;

    // first LFSR step from ACE1 is E270 -> explore index (0xE2*4)>>8 = 3
    load_eps(16'h0100);
    request({16'h0000, 16'h7000, 16'h0000, 16'h0000}, 0, 0, idx, ex);
    chk("pin_first_explore", ex, 1'b1);
    chk("pin_first_idx", idx, 2'd3);

    load_eps(16'h0000);
    request({16'h000C, 16'h0001, 16'h0002, 16'h0003}, 0, 0, idx, ex);
    chk("greedy_idx", idx, 2'd3);
    chk("greedy_explore", ex, 1'b0);
    chk("greedy_action", action, 4'b1000);

    request({16'h8000, 16'hFF00, 16'hFE00, 16'hFF00}, 1, 0, idx, ex);
    chk("neg_tie_idx", idx, 2'd0);
    chk("neg_tie_dut_idx", action_idx, 2'd0);

    load_eps(16'h0100);
    for (int i = 0; i < 20; i++) begin
      request({$urandom, $urandom}, 0, 1, idx, ex);
      chk("full_eps_explore", ex, 1'b1);
    end

    exp_eps = '{16'h00A0, 16'h0060, 16'h0020, 16'h0020};
    eps_step = 16'h0040;
    eps_min  = 16'h0020;
    load_eps(16'h00E0);
    for (int i = 0; i < 4; i++) begin
      request({$urandom, $urandom}, 0, 0, idx, ex);
      chk("decay_seq", epsilon_q, exp_eps[i]);
    end

    eps_step = 16'h0010;
    eps_min  = 16'h0000;
    load_eps(16'h0080);
    request({16'h0001, 16'h0002, 16'h0003, 16'h0004}, 10, 1, idx, ex);
    chk("stall_decay", epsilon_q, 16'h0070);

    eps_step = 16'h0010;
    eps_min  = 16'h0090;
    request({$urandom, $urandom}, 0, 0, idx, ex);
    chk("below_floor_hold", epsilon_q, 16'h0070);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) load_eps(16'($urandom_range(0, 320)));
      eps_step = 16'($urandom_range(0, 96));
      eps_min  = 16'($urandom_range(0, 128));
      request({$urandom, $urandom}, $urandom_range(0, 3), 1, idx, ex);
    end

    @(negedge clk);
    q_values = {16'h0005, 16'h0004, 16'h0003, 16'h0002};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_action", action, 4'd0);
    chk("abort_idx", action_idx, 2'd0);
    chk("abort_epsilon", epsilon_q, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_release_ready", in_ready, 1'b1);
    mon_en = 1'b1;
    repeat (8) @(posedge clk);
    eps_step = 16'h0000;
    eps_min  = 16'h0000;
    load_eps(16'h0100);
    request({16'h0000, 16'h7000, 16'h0000, 16'h0000}, 0, 0, idx, ex);
    chk("rerun_idx", idx, 2'd3);
    chk("rerun_dut_idx", action_idx, 2'd3);
    chk("rerun_explore", explore, 1'b1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
